led_pattern_scheduler: RTL and testbench

Shares the single board LED among NUM_REQ requesters (status, error, heartbeat sources) and plays each granted requester's blink pattern. Replaces the free-running fixed-rate LED toggler: an internal prescaler derives the bit-rate tick from the low-frequency oscillator clock. Arbitration is round-robin. Each grant plays an 8-bit pattern a programmable number of times, then releases the LED.

---
 rtl/led_pattern_scheduler_pkg.sv | 23 ++
 rtl/led_pattern_scheduler_tick_prescaler.sv | 48 ++++
 rtl/led_pattern_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// led_sched_pkg
// Shared definitions for the LED pattern scheduler:
//   - sched_state_e    : scheduler FSM encoding (IDLE=0, PLAY=1, DONE=2)
//   - DEFAULT_TICK_DIV : clk cycles per pattern bit on the LF oscillator
//                        (~1 Hz bit rate; takes over from the old fixed
//                        1 Hz divider macro)
//   - DEFAULT_IDLE_LED : LED level while nothing is playing
//   - DONE_ID_W        : width of the done_id output
// ---------------------------------------------------------------------------
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  localparam int unsigned DEFAULT_TICK_DIV = 10000;
  localparam logic        DEFAULT_IDLE_LED = 1'b0;
  localparam int unsigned DONE_ID_W        = 3;

endpackage

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing the pattern bit-rate tick.
//   clk   : LF oscillator clock
//   reset : synchronous, active-high; counter returns to 0
//   clr   : synchronous clear; holds the counter at 0 while high
//   tick  : one-cycle pulse every DIV cycles, counted from the cycle
//           after clr falls
// ---------------------------------------------------------------------------
module tick_prescaler
  import led_sched_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A cleared counter never reports a tick, so the first bit after a
  // grant is always a full DIV-cycle period.
  assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_scheduler.sv
// ---------------------------------------------------------------------------
// led_pattern_scheduler
// Shares one board LED among NUM_REQ requesters. Requests are arbitrated
// round-robin; the winner's PATTERN_W-bit pattern is played MSB first,
// each bit held TICK_DIV cycles, repeat+1 times, then the LED is released.
//
// Ports:
//   clk_i       : LF oscillator clock, all logic on posedge
//   reset_i     : synchronous, active-high
//   req_i       : level requests, held high by a requester until done
//   pattern_i   : pattern for requester i in slice i (sampled at grant)
//   repeat_i    : extra plays for requester i in slice i (sampled at grant)
//   grant_o     : one-hot, high for the whole play
//   done_o      : one-cycle pulse when a play completes normally
//   done_id_o   : index of the completed requester, valid with done_o
//   busy_o      : high while a pattern is playing
//   led_o       : registered LED drive
// ---------------------------------------------------------------------------
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int unsigned PATTERN_W = 8,
  parameter int unsigned REPEAT_W  = 4,
  parameter logic        IDLE_LED  = DEFAULT_IDLE_LED
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*PATTERN_W-1:0]  pattern_i,
  input  logic [NUM_REQ*REPEAT_W-1:0]   repeat_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          done_o,
  output logic [DONE_ID_W-1:0]          done_id_o,
  output logic                          busy_o,
  output logic                          led_o
);

  localparam int unsigned         IDX_W    = $clog2(NUM_REQ);
  localparam int unsigned         BCW      = $clog2(PATTERN_W) + 1;
  localparam logic [BCW-1:0]      BIT_LAST = BCW'(PATTERN_W - 1);
  localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(NUM_REQ - 1);

  sched_state_e             state_q,   state_d;
  logic [PATTERN_W-1:0]     shift_q,   shift_d;
  logic [PATTERN_W-1:0]     orig_q,    orig_d;
  logic [REPEAT_W-1:0]      rep_q,     rep_d;
  logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]         gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]         last_id_q, last_id_d;
  logic [NUM_REQ-1:0]       grant_q,   grant_d;
  logic [DONE_ID_W-1:0]     done_id_q, done_id_d;
  logic                     led_q,     led_d;

  logic                     presc_clr;
  logic                     tick;
  logic [IDX_W-1:0]         pick_idx;

  // First set request strictly after `last`, wrapping around; `last`
  // itself is considered last of all.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      j;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = (32'(last) + k) % NUM_REQ;
      if (!found && r[IDX_W'(j)]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(req_i, last_id_q);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk_i),
    .reset (reset_i),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    orig_d    = orig_q;
    rep_d     = rep_q;
    bit_cnt_d = bit_cnt_q;
    gnt_idx_d = gnt_idx_q;
    last_id_d = last_id_q;
    grant_d   = grant_q;
    done_id_d = done_id_q;
    presc_clr = 1'b1;
    led_d     = IDLE_LED;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (|req_i) begin
          shift_d   = pattern_i[pick_idx*PATTERN_W +: PATTERN_W];
          orig_d    = pattern_i[pick_idx*PATTERN_W +: PATTERN_W];
          rep_d     = repeat_i[pick_idx*REPEAT_W +: REPEAT_W];
          bit_cnt_d = '0;
          gnt_idx_d = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d   = ST_PLAY;
        end
      end

      ST_PLAY: begin
        presc_clr = 1'b0;
        if (!(|(req_i & grant_q))) begin
          // Abort: release immediately, no done pulse, but still rotate
          // priority past the aborted requester.
          state_d   = ST_IDLE;
          grant_d   = '0;
          last_id_d = gnt_idx_q;
        end else if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (rep_q != '0) begin
              rep_d     = rep_q - 1'b1;
              shift_d   = orig_q;
              bit_cnt_d = '0;
            end else begin
              state_d   = ST_DONE;
              grant_d   = '0;
              done_id_d = DONE_ID_W'(gnt_idx_q);
              last_id_d = gnt_idx_q;
            end
          end else begin
            shift_d   = {shift_q[PATTERN_W-2:0], shift_q[PATTERN_W-1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    // LED is registered: it follows the MSB of the shift register the
    // scheduler is about to hold, so it switches on the same edge as grant.
    if (state_d == ST_PLAY) begin
      led_d = shift_d[PATTERN_W-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      orig_q    <= '0;
      rep_q     <= '0;
      bit_cnt_q <= '0;
      gnt_idx_q <= '0;
      last_id_q <= LAST_RST;
      grant_q   <= '0;
      done_id_q <= '0;
      led_q     <= IDLE_LED;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      orig_q    <= orig_d;
      rep_q     <= rep_d;
      bit_cnt_q <= bit_cnt_d;
      gnt_idx_q <= gnt_idx_d;
      last_id_q <= last_id_d;
      grant_q   <= grant_d;
      done_id_q <= done_id_d;
      led_q     <= led_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = (state_q == ST_DONE);
  assign done_id_o = done_id_q;
  assign busy_o    = (state_q == ST_PLAY);
  assign led_o     = led_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_scheduler
// Self-checking bench for led_pattern_scheduler with TICK_DIV=4, NUM_REQ=4,
// PATTERN_W=8, REPEAT_W=4. Single-requester plays come from a vector table;
// round-robin, simultaneous-request, abort and reset cases are hand-written.
// Expected LED bits and grant order are queued when stimulus is driven and
// popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_led_pattern_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned RW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*PW-1:0]  pattern;
  logic [NR*RW-1:0]  rep_v;
  logic [NR-1:0]     grant;
  logic              done;
  logic [2:0]        done_id;
  logic              busy;
  logic              led;

  int n_vec  = 0;
  int n_miss = 0;

  logic sb_led[$];
  int   sb_gnt[$];

  typedef struct {
    int         id;
    logic [7:0] pat;
    logic [3:0] rep;
    logic [3:0] exp_grant;
    int         exp_cycles;
    int         exp_done_id;
  } vec_t;

  vec_t vecs[5];

  led_pattern_scheduler #(
    .NUM_REQ   (NR),
    .TICK_DIV  (TD),
    .PATTERN_W (PW),
    .REPEAT_W  (RW),
    .IDLE_LED  (1'b0)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .req_i     (req),
    .pattern_i (pattern),
    .repeat_i  (rep_v),
    .grant_o   (grant),
    .done_o    (done),
    .done_id_o (done_id),
    .busy_o    (busy),
    .led_o     (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int id, input logic [7:0] pat, input logic [3:0] rep);
    pattern[id*PW +: PW] = pat;
    rep_v[id*RW +: RW]   = rep;
  endtask

  task automatic push_led(input logic [7:0] pat, input logic [3:0] rep);
    for (int p = 0; p <= int'(rep); p++)
      for (int b = PW - 1; b >= 0; b--)
        for (int c = 0; c < TD; c++)
          sb_led.push_back(pat[b]);
  endtask

  // Returns at the first negedge with a grant; gap counts grant-free
  // negedges seen since the call (including the calling one).
  task automatic wait_grant(output int idx, output int gap);
    idx = -1;
    gap = 0;
    for (int c = 0; c < 400; c++) begin
      if (grant != '0) break;
      gap++;
      @(negedge clk);
    end
    if (grant != '0) begin
      chk("grant_onehot", $countones(grant), 1);
      for (int i = 0; i < NR; i++) if (grant[i]) idx = i;
    end
  endtask

  task automatic wait_done(output int id);
    id = -1;
    for (int c = 0; c < 2000; c++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    if (done === 1'b1) begin
      id = int'(done_id);
      chk("done_grant_low", grant, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, gap, id, cyc, early;
    logic e;

    vecs[0] = '{id: 1, pat: 8'b1011_0000, rep: 4'd0,  exp_grant: 4'b0010, exp_cycles: 32,  exp_done_id: 1};
    vecs[1] = '{id: 2, pat: 8'hF0,        rep: 4'd2,  exp_grant: 4'b0100, exp_cycles: 96,  exp_done_id: 2};
    vecs[2] = '{id: 0, pat: 8'hA5,        rep: 4'd1,  exp_grant: 4'b0001, exp_cycles: 64,  exp_done_id: 0};
    vecs[3] = '{id: 1, pat: 8'h3C,        rep: 4'd15, exp_grant: 4'b0010, exp_cycles: 512, exp_done_id: 1};
    vecs[4] = '{id: 3, pat: 8'h01,        rep: 4'd0,  exp_grant: 4'b1000, exp_cycles: 32,  exp_done_id: 3};

    reset   = 1'b1;
    req     = '0;
    pattern = '0;
    rep_v   = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant",   grant,   0);
    chk("rst_done",    done,    0);
    chk("rst_done_id", done_id, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_led",     led,     0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single plays.
    foreach (vecs[v]) begin
      set_slot(vecs[v].id, vecs[v].pat, vecs[v].rep);
      push_led(vecs[v].pat, vecs[v].rep);
      req = '0;
      req[vecs[v].id] = 1'b1;
      @(negedge clk);
      chk("vec_grant", grant, vecs[v].exp_grant);
      chk("vec_busy",  busy,  1);
      cyc   = 0;
      early = 0;
      while (busy === 1'b1 && cyc < 2000) begin
        e = (sb_led.size() > 0) ? sb_led.pop_front() : 1'bx;
        chk("vec_led", led, e);
        if (done === 1'b1) early++;
        @(negedge clk);
        cyc++;
      end
      chk("vec_play_len",   cyc, vecs[v].exp_cycles);
      chk("vec_led_left",   sb_led.size(), 0);
      chk("vec_early_done", early, 0);
      sb_led.delete();
      chk("vec_done",       done,    1);
      chk("vec_done_id",    done_id, vecs[v].exp_done_id);
      chk("vec_done_grant", grant,   0);
      chk("vec_done_led",   led,     0);
      req = '0;
      @(negedge clk);
      chk("vec_idle_done", done, 0);
      chk("vec_idle_busy", busy, 0);
    end

    // Round-robin with all four requesting; each drops after its done.
    for (int i = 0; i < NR; i++) set_slot(i, 8'h81 + 8'(i), 4'd0);
    for (int i = 0; i < NR; i++) sb_gnt.push_back(i);
    req = 4'hF;
    for (int k = 0; k < NR; k++) begin
      wait_grant(idx, gap);
      chk("rr_order", idx, sb_gnt.pop_front());
      if (k > 0) chk("rr_gap", gap, 2);
      wait_done(id);
      chk("rr_done_id", id, k);
      req[k] = 1'b0;
    end
    @(negedge clk);

    // Requester 0 held continuously while 3 waits.
    sb_gnt.push_back(0);
    sb_gnt.push_back(3);
    sb_gnt.push_back(0);
    req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      wait_grant(idx, gap);
      chk("sim_order", idx, sb_gnt.pop_front());
      if (k > 0) chk("sim_gap", gap, 2);
      wait_done(id);
      chk("sim_done_id", id, idx);
      if (k == 1) req[3] = 1'b0;
      if (k == 2) req[0] = 1'b0;
    end
    @(negedge clk);

    // Abort requester 1 ten cycles into its play; 2 is pending.
    set_slot(1, 8'hFF, 4'd3);
    set_slot(2, 8'hFF, 4'd0);
    req = 4'b0110;
    wait_grant(idx, gap);
    chk("ab_grant", idx, 1);
    repeat (10) @(negedge clk);
    chk("ab_led_before", led,  1);
    chk("ab_busy_before", busy, 1);
    req[1] = 1'b0;
    @(negedge clk);
    chk("ab_grant_off", grant, 0);
    chk("ab_led_off",   led,   0);
    chk("ab_busy_off",  busy,  0);
    chk("ab_no_done",   done,  0);
    @(negedge clk);
    chk("ab_next_grant", grant, 4'b0100);
    chk("ab_no_done2",   done,  0);

    // Reset at cycle 15 of requester 2's play.
    repeat (14) @(negedge clk);
    chk("rs_busy_before", busy, 1);
    reset = 1'b1;
    req   = 4'hF;
    @(negedge clk);
    chk("rs_grant",   grant,   0);
    chk("rs_busy",    busy,    0);
    chk("rs_led",     led,     0);
    chk("rs_done",    done,    0);
    chk("rs_done_id", done_id, 0);
    reset = 1'b0;
    wait_grant(idx, gap);
    chk("rs_priority", idx, 0);
    chk("rs_gap",      gap, 1);
    req = '0;
    repeat (2) @(negedge clk);
    chk("end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
